// File: rtl/cim_mem_arbiter_pkg.sv
// Shared CiM storage types: access-source ids and temp-result SRAM geometry
// used by the memory arbiter and its round-robin picker.
package cim_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    BUS_FSM   = 3'd0,
    LOGIC_FSM = 3'd1,
    MAC       = 3'd2,
    LAYERNORM = 3'd3,
    SOFTMAX   = 3'd4
  } MEM_ACCESS_SRC_T;

  localparam int MEM_ACCESS_SRC_NUM        = 5;
  localparam int TEMP_RES_STORAGE_SIZE_CIM = 256;
  localparam int N_STORAGE                 = 16;
  localparam int RR_PTR_W                  = 3;

endpackage

// File: rtl/cim_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: the first requester at or after ptr
// (wrapping modulo N) wins, returned one-hot. Reusable by other CiM arbiters.
module cim_rr_picker #(
  parameter int N     = 5,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     win
);

  logic found;
  int   idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cim_mem_arbiter.sv
// Single-port temp-result SRAM arbiter for the CiM's five access sources.
// Optional CIM_MEM_ARB_BUS_PRIORITY_EN: BUS_FSM always wins over round-robin.
module cim_mem_arbiter
  import cim_mem_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = MEM_ACCESS_SRC_NUM,
  parameter int ADDR_W     = $clog2(TEMP_RES_STORAGE_SIZE_CIM),
  parameter int DATA_W     = N_STORAGE,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  read_req_src,
  input  logic [NUM_SRC-1:0]  write_req_src,
  input  logic [ADDR_W-1:0]   addr_table [NUM_SRC],
  input  logic [DATA_W-1:0]   write_data [NUM_SRC],
  output logic [NUM_SRC-1:0]  gnt,
  output logic [NUM_SRC-1:0]  rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_dual_req
);

  logic [NUM_SRC-1:0]  req_vec;
  logic [NUM_SRC-1:0]  rr_win;
  logic [NUM_SRC-1:0]  win;
  logic                ptr_adv;
  logic [RR_PTR_W-1:0] rr_ptr_reg;
  logic [RR_PTR_W-1:0] rr_ptr_next;
  logic [RR_PTR_W-1:0] win_idx;
  logic                win_is_write;
  logic                win_is_dual;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                mem_en_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic                err_reg;

  // Requests are masked while in reset so gnt stays low regardless of inputs.
  assign req_vec = (read_req_src | write_req_src) & {NUM_SRC{rst_n}};

  cim_rr_picker #(
    .N     (NUM_SRC),
    .PTR_W (RR_PTR_W)
  ) u_picker (
    .req (req_vec),
    .ptr (rr_ptr_reg),
    .win (rr_win)
  );

`ifdef CIM_MEM_ARB_BUS_PRIORITY_EN
  // The inter-CiM bus must never stall; its grants leave the pointer alone.
  assign win     = req_vec[0] ? NUM_SRC'(1) : rr_win;
  assign ptr_adv = |win[NUM_SRC-1:1];
`else
  assign win     = rr_win;
  assign ptr_adv = |win;
`endif

  always_comb begin
    win_idx   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (win[i]) begin
        win_idx   = RR_PTR_W'(i);
        sel_addr  = addr_table[i];
        sel_wdata = write_data[i];
      end
    end
  end

  // A simultaneous read+write from the winner performs the write only.
  assign win_is_write = |(win & write_req_src);
  assign win_is_dual  = |(win & write_req_src & read_req_src);
  assign rr_ptr_next  = (win_idx == RR_PTR_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (ptr_adv) rr_ptr_reg <= rr_ptr_next;
      mem_en_reg <= |win;
      mem_we_reg <= win_is_write;
      if (|win) mem_addr_reg <= sel_addr;
      if (win_is_write) mem_wdata_reg <= sel_wdata;
      err_reg <= win_is_dual;
    end
  end

  // Read-return pipeline: stage 0 aligns with the SRAM command, the last
  // stage lines up with mem_rdata MEM_RD_LAT cycles later.
  genvar gi;
  generate
    for (gi = 0; gi <= MEM_RD_LAT; gi++) begin : g_rd_pipe
      logic [NUM_SRC-1:0] stage_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_reg <= '0;
          else        stage_reg <= win_is_write ? '0 : win;
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_reg <= '0;
          else        stage_reg <= g_rd_pipe[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign gnt          = win;
  assign rd_valid     = g_rd_pipe[MEM_RD_LAT].stage_reg;
  assign rd_data      = mem_rdata;
  assign mem_en       = mem_en_reg;
  assign mem_we       = mem_we_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign err_dual_req = err_reg;

endmodule

// File: tb/tb_cim_mem_arbiter.sv
// Directed bench for cim_mem_arbiter with a 1-cycle-latency SRAM model:
// a vector table for round-robin/command behaviour plus hand-written corner cases.
`timescale 1ns/1ps
module tb_cim_mem_arbiter;
  import cim_mem_arbiter_pkg::*;

  localparam int NS = 5;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] read_req_src;
  logic [NS-1:0] write_req_src;
  logic [AW-1:0] addr_table [NS];
  logic [DW-1:0] write_data [NS];
  logic [NS-1:0] gnt;
  logic [NS-1:0] rd_valid;
  logic [DW-1:0] rd_data;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          err_dual_req;

  logic [DW-1:0] sram [256];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NS-1:0] rd;
    logic [NS-1:0] wr;
    logic [NS-1:0] gnt;
    logic          we;
  } vec_t;

  vec_t vt [12];

  always #5 clk = ~clk;

  cim_mem_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_req_src  (read_req_src),
    .write_req_src (write_req_src),
    .addr_table    (addr_table),
    .write_data    (write_data),
    .gnt           (gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .err_dual_req  (err_dual_req)
  );

  // SRAM model: registered read, one cycle after the command.
  always @(posedge clk) begin
    if (pre_we) sram[pre_addr] <= pre_data;
    else if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= sram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_we   = 1'b0;
  endtask

  function automatic int oh2idx(input logic [NS-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < NS; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic default_addrs();
    for (int i = 0; i < NS; i++) begin
      addr_table[i] = AW'(8'h20 + i);
      write_data[i] = DW'(16'h100 + i);
    end
  endtask

  initial begin
    logic [NS-1:0] exp_rv;
    logic [NS-1:0] exp_g;

    // rd, wr, expected gnt, expected mem_we; pointer is 3 on entry
    vt[0]  = '{5'b11111, 5'b00000, 5'b01000, 1'b0};
    vt[1]  = '{5'b11111, 5'b00000, 5'b10000, 1'b0};
    vt[2]  = '{5'b00110, 5'b00000, 5'b00010, 1'b0};
    vt[3]  = '{5'b00010, 5'b00000, 5'b00010, 1'b0};
    vt[4]  = '{5'b00000, 5'b00000, 5'b00000, 1'b0};
    vt[5]  = '{5'b00001, 5'b10000, 5'b10000, 1'b1};
    vt[6]  = '{5'b00001, 5'b10000, 5'b00001, 1'b0};
    vt[7]  = '{5'b00000, 5'b00001, 5'b00001, 1'b1};
    vt[8]  = '{5'b11100, 5'b00000, 5'b00100, 1'b0};
    vt[9]  = '{5'b10101, 5'b00000, 5'b10000, 1'b0};
    vt[10] = '{5'b00000, 5'b00000, 5'b00000, 1'b0};
    vt[11] = '{5'b00000, 5'b00000, 5'b00000, 1'b0};

    rst_n         = 1'b0;
    read_req_src  = '1;
    write_req_src = '0;
    pre_we        = 1'b0;
    pre_addr      = '0;
    pre_data      = '0;
    default_addrs();
    step();
    preload(8'h12, 16'hABC);
    for (int i = 0; i < NS; i++) preload(AW'(8'h20 + i), DW'(16'h100 + i));
    preload(8'h07, 16'h0);
    preload(8'h09, 16'h0);

    check("rst_gnt", gnt, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_err", err_dual_req, 0);
    read_req_src = '0;
    step();
    rst_n = 1'b1;
    step();

    // Single MAC read of 0x12
    addr_table[int'(MAC)] = 8'h12;
    read_req_src = 5'b00100;
    #1 check("mac_gnt", gnt, 5'b00100);
    step();
    read_req_src = '0;
    check("mac_mem_en", mem_en, 1);
    check("mac_mem_we", mem_we, 0);
    check("mac_mem_addr", mem_addr, 8'h12);
    check("mac_rd_valid_early", rd_valid, 0);
    step();
    check("mac_rd_valid", rd_valid, 5'b00100);
    check("mac_rd_data", rd_data, 16'hABC);
    $display("txn mac_read addr=0x12 rd_valid=%b rd_data=0x%0h", rd_valid, rd_data);
    default_addrs();

`ifdef CIM_MEM_ARB_BUS_PRIORITY_EN
    read_req_src = 5'b00101;
    for (int c = 0; c < 3; c++) begin
      #1 check("prio_bus_gnt", gnt, 5'b00001);
      $display("txn prio cycle=%0d gnt=%b", c, gnt);
      step();
    end
    read_req_src = 5'b00100;
    #1 check("prio_mac_gnt", gnt, 5'b00100);
    step();
    read_req_src = '0;
`else
    for (int k = 0; k < 12; k++) begin
      read_req_src  = vt[k].rd;
      write_req_src = vt[k].wr;
      #1 check("tbl_gnt", gnt, vt[k].gnt);
      $display("txn vec=%0d rd=%b wr=%b gnt=%b", k, vt[k].rd, vt[k].wr, gnt);
      step();
      check("tbl_mem_en", mem_en, |vt[k].gnt);
      check("tbl_mem_we", mem_we, vt[k].we);
      exp_rv = '0;
      if (k >= 1 && !vt[k-1].we) exp_rv = vt[k-1].gnt;
      check("tbl_rd_valid", rd_valid, exp_rv);
      if (exp_rv != '0) check("tbl_rd_data", rd_data, 32'h100 + oh2idx(exp_rv));
    end
    read_req_src  = '0;
    write_req_src = '0;

    // Write from LAYERNORM then read by SOFTMAX of the same address
    addr_table[3] = 8'h07;
    write_data[3] = 16'h55;
    write_req_src = 5'b01000;
    #1 check("raw_wr_gnt", gnt, 5'b01000);
    step();
    write_req_src = '0;
    addr_table[4] = 8'h07;
    read_req_src  = 5'b10000;
    #1 check("raw_rd_gnt", gnt, 5'b10000);
    step();
    read_req_src = '0;
    check("raw_no_valid", rd_valid, 0);
    step();
    check("raw_rd_valid", rd_valid, 5'b10000);
    check("raw_rd_data", rd_data, 16'h55);
    $display("txn raw addr=7 rd_valid=%b rd_data=0x%0h", rd_valid, rd_data);

    // LOGIC_FSM dual request
    addr_table[1] = 8'h09;
    write_data[1] = 16'h77;
    read_req_src  = 5'b00010;
    write_req_src = 5'b00010;
    #1 check("dual_gnt", gnt, 5'b00010);
    step();
    read_req_src  = '0;
    write_req_src = '0;
    check("dual_mem_we", mem_we, 1);
    check("dual_err_pulse", err_dual_req, 1);
    step();
    check("dual_err_clear", err_dual_req, 0);
    check("dual_no_valid_a", rd_valid, 0);
    check("dual_sram", sram[9], 16'h77);
    step();
    check("dual_no_valid_b", rd_valid, 0);
    $display("txn dual addr=9 sram=0x%0h err=%b", sram[9], err_dual_req);
    default_addrs();

    // Reset one cycle after a MAC read grant
    read_req_src = 5'b00100;
    #1 check("rmid_gnt", gnt, 5'b00100);
    step();
    rst_n        = 1'b0;
    read_req_src = '1;
    #1;
    check("rmid_gnt_masked", gnt, 0);
    check("rmid_mem_en", mem_en, 0);
    check("rmid_mem_we", mem_we, 0);
    check("rmid_mem_addr", mem_addr, 0);
    check("rmid_mem_wdata", mem_wdata, 0);
    check("rmid_err", err_dual_req, 0);
    check("rmid_rd_valid", rd_valid, 0);
    for (int c = 0; c < 2; c++) begin
      step();
      check("rmid_rd_valid_hold", rd_valid, 0);
    end
    rst_n = 1'b1;

    // All five read continuously from a fresh pointer
    for (int c = 0; c < 12; c++) begin
      if (c == 10) read_req_src = '0;
      #1;
      exp_g = (c < 10) ? NS'(1 << (c % 5)) : '0;
      check("all5_gnt", gnt, exp_g);
      exp_rv = (c >= 2) ? NS'(1 << ((c - 2) % 5)) : '0;
      check("all5_rd_valid", rd_valid, exp_rv);
      if (exp_rv != '0) check("all5_rd_data", rd_data, 32'h100 + oh2idx(exp_rv));
      $display("txn all5 cycle=%0d gnt=%b rd_valid=%b", c, gnt, rd_valid);
      step();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
